// File: rtl/kyber_pkg.sv
// Shared Kyber constants, sampler state encoding and squeeze byte-order convention.
// Squeeze byte order: stream byte k of a 64-bit word sits at bits [63-8k -: 8].
package kyber_pkg;
  localparam int KYBER_N  = 256;
  localparam int KYBER_Q  = 3329;
  localparam int BW_COEF  = 12;
  localparam int WORD_W   = 64;
  localparam int BUF_W    = 80;
  localparam int BCNT_W   = 7;
  localparam int IDX_W    = 8;
  localparam int CNT_W    = 9;

  localparam logic [BW_COEF-1:0] Q_C      = BW_COEF'(KYBER_Q);
  localparam logic [CNT_W-1:0]   N_C      = CNT_W'(KYBER_N);
  localparam logic [BCNT_W-1:0]  TRIPLE_BITS = BCNT_W'(24);
  localparam logic [BCNT_W-1:0]  LOAD_MAX    = BCNT_W'(16);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_SAMPLE = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/rej_byte_buffer.sv
// 80-bit byte-oriented bit buffer for the Parse sampler: oldest byte at the MSB end,
// appends 64-bit squeeze words below the residue and exposes the two 12-bit candidates.
module rej_byte_buffer
  import kyber_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic                 load,
  input  logic [WORD_W-1:0]    word,
  input  logic                 shift,
  output logic [BCNT_W-1:0]    bcnt,
  output logic [BW_COEF-1:0]   d1,
  output logic [BW_COEF-1:0]   d2
);

  logic [BUF_W-1:0] bits;

  // Unused low bits are always zero, so a load can simply OR the new word in below the residue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bits <= '0;
      bcnt <= '0;
    end else if (clear) begin
      bits <= '0;
      bcnt <= '0;
    end else if (load) begin
      bits <= bits | ({word, 16'b0} >> bcnt);
      bcnt <= bcnt + BCNT_W'(64);
    end else if (shift) begin
      bits <= bits << 24;
      bcnt <= bcnt - TRIPLE_BITS;
    end
  end

  // b0 = bits[79:72], b1 = bits[71:64], b2 = bits[63:56]
  assign d1 = {bits[67:64], bits[79:72]};
  assign d2 = {bits[63:56], bits[71:68]};

endmodule

// File: rtl/rej_uniform_sampler.sv
// Kyber Parse: rejection-samples the SHAKE128 squeeze stream into N coefficients mod Q.
// Optional statistics ports (o_rej_cnt, o_word_cnt) are built when REJ_SAMPLER_STAT_EN is defined.
module rej_uniform_sampler
  import kyber_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [WORD_W-1:0]  i_obytes,
  input  logic               i_obytes_valid,
  input  logic               i_obytes_last,
  output logic               o_obytes_ready,
  output logic [BW_COEF-1:0] o_coef,
  output logic               o_coef_valid,
  output logic [IDX_W-1:0]   o_coef_idx,
  output logic               o_done,
  output logic               o_short,
`ifdef REJ_SAMPLER_STAT_EN
  output logic [9:0]         o_rej_cnt,
  output logic [7:0]         o_word_cnt,
`endif
  output state_t             o_state
);

  state_t             state;
  logic               half;
  logic               last_seen;
  logic [CNT_W-1:0]   cnt;
  logic [BCNT_W-1:0]  bcnt;
  logic [BW_COEF-1:0] d1, d2, cand;
  logic               hs, can_eval, sampling, accept, final_acc;

  // Word handshake: a word transfers on a rising edge where i_obytes_valid && o_obytes_ready;
  // the producer holds word, valid and last stable until then. Ready depends only on registers.
  assign o_obytes_ready = (state == S_DRAIN) ||
                          ((state == S_FILL || state == S_SAMPLE) && bcnt <= LOAD_MAX && !half);
  assign hs        = i_obytes_valid && o_obytes_ready;
  assign can_eval  = bcnt >= TRIPLE_BITS;
  assign sampling  = (state == S_SAMPLE) && can_eval;
  assign cand      = half ? d2 : d1;
  assign accept    = cand < Q_C;
  assign final_acc = sampling && accept && (cnt == N_C - CNT_W'(1));
  assign o_state   = state;

  rej_byte_buffer u_buf (
    .clk   (i_clk),
    .rstn  (i_rstn),
    .clear ((state == S_IDLE && i_start) || final_acc),
    .load  (hs && state != S_DRAIN),
    .word  (i_obytes),
    .shift (sampling && half && !final_acc),
    .bcnt  (bcnt),
    .d1    (d1),
    .d2    (d2)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= S_IDLE;
      half         <= 1'b0;
      last_seen    <= 1'b0;
      cnt          <= '0;
      o_coef       <= '0;
      o_coef_valid <= 1'b0;
      o_coef_idx   <= '0;
      o_done       <= 1'b0;
      o_short      <= 1'b0;
    end else begin
      o_coef_valid <= 1'b0;
      o_done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            half      <= 1'b0;
            last_seen <= 1'b0;
            cnt       <= '0;
            o_short   <= 1'b0;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (hs && i_obytes_last) last_seen <= 1'b1;
          if (can_eval) state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (hs && i_obytes_last) last_seen <= 1'b1;
          if (can_eval) begin
            if (accept) begin
              o_coef       <= cand;
              o_coef_valid <= 1'b1;
              o_coef_idx   <= cnt[IDX_W-1:0];
              if (cnt != N_C) cnt <= cnt + CNT_W'(1);
            end
            // The N-th acceptance drops whatever is still buffered, including a pending d2.
            if (final_acc) begin
              half <= 1'b0;
              if (last_seen) begin
                state  <= S_DONE;
                o_done <= 1'b1;
              end else begin
                state <= S_DRAIN;
              end
            end else begin
              half <= !half;
            end
          end else if (last_seen) begin
            o_short <= 1'b1;
            o_done  <= 1'b1;
            state   <= S_DONE;
          end else begin
            state <= S_FILL;
          end
        end
        S_DRAIN: begin
          if (hs && i_obytes_last) begin
            o_done <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef REJ_SAMPLER_STAT_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_rej_cnt  <= '0;
      o_word_cnt <= '0;
    end else if (state == S_IDLE && i_start) begin
      o_rej_cnt  <= '0;
      o_word_cnt <= '0;
    end else begin
      if (sampling && !accept && o_rej_cnt != 10'h3FF) o_rej_cnt <= o_rej_cnt + 10'd1;
      if (hs && o_word_cnt != 8'hFF) o_word_cnt <= o_word_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rej_uniform_sampler.sv
// Directed + randomized bench for rej_uniform_sampler against a byte-level Parse model.
module tb_rej_uniform_sampler;
  import kyber_pkg::*;

  // clock / reset
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [63:0] obytes = '0;
  logic        obytes_valid = 1'b0;
  logic        obytes_last = 1'b0;
  logic        obytes_ready;
  logic [11:0] coef;
  logic        coef_valid;
  logic [7:0]  coef_idx;
  logic        done;
  logic        short_err;
  state_t      state;
`ifdef REJ_SAMPLER_STAT_EN
  logic [9:0]  rej_cnt;
  logic [7:0]  word_cnt;
`endif

  always #5 clk = ~clk;

  rej_uniform_sampler dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_start        (start),
    .i_obytes       (obytes),
    .i_obytes_valid (obytes_valid),
    .i_obytes_last  (obytes_last),
    .o_obytes_ready (obytes_ready),
    .o_coef         (coef),
    .o_coef_valid   (coef_valid),
    .o_coef_idx     (coef_idx),
    .o_done         (done),
    .o_short        (short_err),
`ifdef REJ_SAMPLER_STAT_EN
    .o_rej_cnt      (rej_cnt),
    .o_word_cnt     (word_cnt),
`endif
    .o_state        (state)
  );

  // scoreboard
  int          checks = 0;
  int          failures = 0;
  logic [11:0] exp_q[$];
  logic [11:0] got_coef_q[$];
  logic [7:0]  got_idx_q[$];
  logic [7:0]  stream_q[$];
  int          done_cnt = 0;
  int          got_base = 0;
  int          done_base = 0;
  logic        exp_short;

  always @(negedge clk) begin
    if (coef_valid === 1'b1) begin
      got_coef_q.push_back(coef);
      got_idx_q.push_back(coef_idx);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Parse straight from the byte stream: triples -> d1, d2; keep those below Q, stop at N.
  function automatic void parse_model();
    exp_q.delete();
    for (int i = 0; i + 2 < stream_q.size() && exp_q.size() < KYBER_N; i += 3) begin
      int b0 = int'(stream_q[i]);
      int b1 = int'(stream_q[i+1]);
      int b2 = int'(stream_q[i+2]);
      int v1 = b0 + 256 * (b1 % 16);
      int v2 = (b1 / 16) + 16 * b2;
      if (v1 < KYBER_Q) exp_q.push_back(12'(v1));
      if (exp_q.size() < KYBER_N && v2 < KYBER_Q) exp_q.push_back(12'(v2));
    end
    exp_short = (exp_q.size() < KYBER_N);
  endfunction

  // driver tasks
  task automatic begin_run();
    got_base  = got_coef_q.size();
    done_base = done_cnt;
    stream_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_clears_short", short_err, 0);
    chk("start_enters_fill", 32'(state), 32'(S_FILL));
  endtask

  task automatic send_word(input logic [63:0] w, input logic last, input int gap);
    logic ok;
    ok = 1'b0;
    repeat (gap + 1) @(posedge clk);
    #1;
    obytes       = w;
    obytes_valid = 1'b1;
    obytes_last  = last;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (obytes_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    obytes_valid = 1'b0;
    obytes_last  = 1'b0;
    chk("word_handshake", ok, 1);
    for (int k = 0; k < 8; k++) stream_q.push_back(w[63-8*k -: 8]);
  endtask

  task automatic end_run(input string tag);
    logic seen;
    int   n_got, n_cmp;
    seen = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (done_cnt > done_base) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    repeat (2) @(negedge clk);
    parse_model();
    chk({tag, "_done_pulses"}, done_cnt - done_base, 1);
    chk({tag, "_state_idle"}, 32'(state), 32'(S_IDLE));
    chk({tag, "_short"}, short_err, exp_short);
    n_got = got_coef_q.size() - got_base;
    chk({tag, "_coef_count"}, n_got, exp_q.size());
    n_cmp = (n_got < exp_q.size()) ? n_got : exp_q.size();
    for (int i = 0; i < n_cmp; i++) begin
      chk($sformatf("%s_coef[%0d]", tag, i), got_coef_q[got_base+i], exp_q[i]);
      chk($sformatf("%s_idx[%0d]", tag, i), got_idx_q[got_base+i], i);
    end
  endtask

  function automatic logic [63:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", obytes_ready, 0);
    chk("rst_coef_valid", coef_valid, 0);
    chk("rst_coef", coef, 0);
    chk("rst_idx", coef_idx, 0);
    chk("rst_done", done, 0);
    chk("rst_short", short_err, 0);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    rstn = 1'b1;

    // first triple 01 02 03: 513 then 48, one per cycle after the fill latency
    begin_run();
    send_word(64'h0102030405060708, 1'b0, 0);
    @(negedge clk);
    chk("t1_ready_low_after_load", obytes_ready, 0);
    chk("t1_no_coef_c1", coef_valid, 0);
    @(negedge clk);
    chk("t1_no_coef_c2", coef_valid, 0);
    @(negedge clk);
    chk("t1_valid0", coef_valid, 1);
    chk("t1_coef0", coef, 513);
    chk("t1_idx0", coef_idx, 0);
    @(negedge clk);
    chk("t1_valid1", coef_valid, 1);
    chk("t1_coef1", coef, 48);
    chk("t1_idx1", coef_idx, 1);
    send_word(64'h090A0B0C0D0E0F10, 1'b1, 0);
    end_run("t1");

    // Q-1 accepted, Q rejected
    begin_run();
    send_word(64'h000DFF010DFFFFFF, 1'b1, 0);
    end_run("t2_qbound");

    // all-FF stream: nothing accepted, stream runs out
    begin_run();
    for (int k = 0; k < 3; k++) send_word(64'hFFFF_FFFF_FFFF_FFFF, (k == 2), 0);
    end_run("t3_allff");

    // full random polynomial with surplus words drained
    begin_run();
    for (int k = 0; k < 63; k++) send_word(rand_word(), (k == 62), 0);
    end_run("t4_rand");

    // straddling triples with valid gaps; a stray start mid-run must be ignored
    begin_run();
    send_word(rand_word(), 1'b0, 3);
    @(negedge clk);
    chk("t5_ready_low_after_load", obytes_ready, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_word(rand_word(), 1'b0, 5);
    send_word(rand_word(), 1'b1, 4);
    end_run("t5_gaps");

    // reset in the middle of sampling, then a clean run
    begin_run();
    send_word(rand_word(), 1'b0, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("t6_rst_ready", obytes_ready, 0);
    chk("t6_rst_coef_valid", coef_valid, 0);
    chk("t6_rst_coef", coef, 0);
    chk("t6_rst_idx", coef_idx, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_state", 32'(state), 32'(S_IDLE));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    obytes = rand_word();
    obytes_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_ready_without_start", obytes_ready, 0);
    end
    obytes_valid = 1'b0;
    begin_run();
    for (int k = 0; k < 12; k++) send_word(rand_word(), (k == 11), $urandom_range(0, 2));
    end_run("t6_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rej_uniform_sampler.md
Name: rej_uniform_sampler

Overview:
- Consumer on the squeeze side of the SHAKE128 sponge. Takes the 64-bit output word stream and applies Kyber Parse (uniform rejection sampling mod q).
- Emits exactly N accepted 12-bit coefficients of one polynomial in index order, then pulses done.
- Sits between the keccak core and the polynomial RAM / NTT-domain matrix generator (A-hat expansion).

Parameters:
- N, 256, coefficients per polynomial
- Q, 3329, modulus; candidates >= Q are rejected
- BW_COEF, 12, coefficient width

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start pulse; honoured only in S_IDLE
- i_obytes  in  64  squeeze word; stream byte 0 = [63:56], byte 7 = [7:0]
- i_obytes_valid  in  1  word valid
- i_obytes_last  in  1  qualifies the final word of the squeeze stream
- o_obytes_ready  out  1  word accepted when valid && ready
- o_coef  out  BW_COEF  accepted coefficient
- o_coef_valid  out  1  o_coef/o_coef_idx valid this cycle
- o_coef_idx  out  8  coefficient index 0..N-1
- o_done  out  1  one-cycle pulse when the block finishes
- o_short  out  1  sticky error: stream ended before N coefficients were accepted; cleared by i_start

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM is in S_IDLE.
  - Bit buffer, bit count, half flag and coefficient counter are 0.
- Bit buffer:
  - 80 bits; byte-oriented, oldest byte at the MSB end.
  - Bit count bcnt is one of 0, 8, …, 80.
- Word load:
  - o_obytes_ready = 1 in S_FILL/S_SAMPLE when bcnt <= 16 and half == 0.
  - A load appends 64 bits below the existing bytes and adds 64 to bcnt.
  - Load and consume never coincide: consuming requires bcnt >= 24.
- Candidates, with b0, b1, b2 the oldest three buffered bytes:
  - d1 = b0 + 256*(b1 & 0xF).
  - d2 = (b1 >> 4) + 16*b2.
- One candidate is evaluated per cycle, only when bcnt >= 24:
  - half 0 evaluates d1, then half <= 1.
  - half 1 evaluates d2, then shifts out 24 bits, bcnt -= 24, half <= 0.
- Acceptance: candidate < Q. Output is registered, so o_coef_valid rises exactly 1 cycle after the evaluation cycle. o_coef_idx = number of coefficients accepted before this one. o_coef_valid is never asserted twice for the same idx.
- FSM states:
  - S_IDLE: ready = 0. On i_start: clear counters, buffer and o_short, then go to S_FILL.
  - S_FILL: wait until bcnt >= 24, then go to S_SAMPLE.
  - S_SAMPLE: evaluate one candidate per cycle.
    - On the N-th acceptance: go to S_DRAIN if last has not yet been accepted, else S_DONE. Remaining candidates in the buffer are discarded; a pending d2 of the same triple is never evaluated.
    - If bcnt < 24 and last was already accepted: set o_short and go to S_DONE.
    - If bcnt < 24 and more words are pending: go to S_FILL.
  - S_DRAIN: o_obytes_ready = 1; discard words. Accepting a word with last = 1 goes to S_DONE.
  - S_DONE: o_done = 1 for one cycle, then S_IDLE.
- Boundary conditions:
  - Candidate == Q-1 is accepted; candidate == Q is rejected.
  - Triples may straddle words; residual 8 or 16 bits carry over.
  - Coefficient counter is 9 bits; it saturates logic at N and never wraps.
  - i_start outside S_IDLE is ignored.
  - Reset mid-operation aborts immediately. No partial o_done is issued. Subsequent input words are not accepted until a new i_start.
  - The producer must hold i_obytes/i_obytes_valid/i_obytes_last stable until the handshake completes.
- Throughput: 1 candidate per cycle. At most ~5.3 candidates per 64-bit word, so the producer is stalled via ready.

Optional Feature:
- Macro: REJ_SAMPLER_STAT_EN.
- Defined:
  - Extra port o_rej_cnt (out, 10 bits): count of rejected candidates since the last i_start, saturating at 1023.
  - Extra port o_word_cnt (out, 8 bits): count of words accepted since the last i_start, including drained words.
  - Both hold their value after o_done.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package kyber_pkg: KYBER_N = 256, KYBER_Q = 3329, BW_COEF = 12, the squeeze byte-order convention, and the state encoding constants.
- One sub-module: rej_byte_buffer. It holds the 80-bit buffer, bcnt, load/shift control and the d1/d2 extraction.
- The top level keeps the FSM, acceptance compare and counters.

Test Plan:
- Bytes 01 02 03 (rest filling, all valid) -> first outputs coef = 513 at idx 0, then coef = 48 at idx 1, each 1 cycle after its evaluation.
- Bytes 00 0D xx and 01 0D xx in consecutive triples -> 3328 accepted; 3329 rejected with no o_coef_valid and idx not advanced.
- All-FF stream of 3 words with last on word 3 -> no coefficients; o_short = 1; o_done pulse; 24 bytes consumed; state returns to S_IDLE.
- Random 504-byte stream (63 words, last on 63) vs. golden Parse model -> 256 coefficients identical in order and idx. Surplus words are drained with ready = 1, then o_done. No residual candidate is emitted after idx 255.
- Word boundary: 3 words with valid gaps -> straddling triples (bytes 6, 7 of word k plus byte 0 of word k+1) decode correctly. Ready deasserts whenever bcnt > 16.
- Assert i_rstn low mid-S_SAMPLE, release, pulse i_start -> outputs 0 during reset; new run starts at idx 0 with o_short cleared.
